// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and the branch record type for the resolve tracker
package bp_pkg;

    localparam int BHT_IDX_W   = 5;
    localparam int INSTR_BYTES = 4;
    localparam int BP_ADDR_W   = 64;

    // Lowest PC bit used for the BHT index; instructions are word aligned.
    localparam int IDX_LSB = $clog2(INSTR_BYTES);

    typedef struct packed {
        logic [BP_ADDR_W-1:0] pc;
        logic                 pred;
    } bp_rec_t;

endpackage

// File: rtl/branch_rec_fifo.sv
// rtl/branch_rec_fifo.sv - in-order circular queue of branch records with flush
module branch_rec_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  bp_rec_t          wr_data,
    output bp_rec_t          rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    bp_rec_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]) &&
                     (rd_ptr[PTR_W-2:0] == wr_ptr[PTR_W-2:0]);
    assign empty   = (rd_ptr == wr_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[PTR_W-2:0]];

    // Flush wins over push: a push alongside a flush is wrong-path.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-2:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_tracker.sv
// rtl/branch_resolve_tracker.sv - tracks in-flight branch predictions, drives BHT updates and redirects
module branch_resolve_tracker
    import bp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [ADDR_W-1:0]          fetch_pc,
    input  logic                       fetch_pred_taken,
    output logic                       fetch_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic [ADDR_W-1:0]          resolve_target,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_addr,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       underflow_err
);

    bp_rec_t           push_rec;
    bp_rec_t           head;
    logic [ADDR_W-1:0] head_pc;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    logic              mis_now;

    always_comb begin
        push_rec      = '0;
        push_rec.pc   = BP_ADDR_W'(fetch_pc);
        push_rec.pred = fetch_pred_taken;
    end

    assign head_pc     = head.pc[ADDR_W-1:0];
    assign fetch_ready = !full;
    assign do_push     = fetch_valid && fetch_ready;
    assign do_pop      = resolve_valid && !empty;
    assign mis_now     = do_pop && (head.pred != resolve_taken);

    // A mispredict flushes every younger record on the same edge as the pop.
    branch_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (do_push),
        .pop     (do_pop),
        .flush   (mis_now),
        .wr_data (push_rec),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid     <= 1'b0;
            upd_addr      <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid  <= do_pop;
            mispredict <= mis_now;
            if (do_pop) begin
                upd_addr  <= head_pc[IDX_LSB +: IDX_W];
                upd_taken <= resolve_taken;
            end
            if (mis_now) begin
                redirect_pc <= resolve_taken ? resolve_target
                                             : head_pc + ADDR_W'(INSTR_BYTES);
            end
            if (resolve_valid && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb/tb_branch_resolve_tracker.sv - directed and random checks of branch_resolve_tracker against a queue model
module tb_branch_resolve_tracker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_pc = '0;
    logic        fetch_pred_taken = 1'b0;
    logic        fetch_ready;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [63:0] resolve_target = '0;
    logic        upd_valid;
    logic [4:0]  upd_addr;
    logic        upd_taken;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [2:0]  occupancy;
    logic        underflow_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic        pred;
    } mrec_t;

    mrec_t mq[$];
    logic  m_uf = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_tracker dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .fetch_ready      (fetch_ready),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .upd_valid        (upd_valid),
        .upd_addr         (upd_addr),
        .upd_taken        (upd_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .occupancy        (occupancy),
        .underflow_err    (underflow_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model applies the queue rules, then all outputs are compared.
    task automatic cyc(input logic fv, input logic [63:0] pc, input logic pt,
                       input logic rv, input logic rt, input logic [63:0] tgt);
        logic        e_upd;
        logic        e_mis;
        logic [4:0]  e_addr;
        logic [63:0] e_redir;
        mrec_t       r;
        int          sz;
        e_upd   = 1'b0;
        e_mis   = 1'b0;
        e_addr  = '0;
        e_redir = '0;
        fetch_valid      = fv;
        fetch_pc         = pc;
        fetch_pred_taken = pt;
        resolve_valid    = rv;
        resolve_taken    = rt;
        resolve_target   = tgt;
        sz = mq.size();
        #1;
        chk("fetch_ready", {63'd0, fetch_ready}, {63'd0, sz < DEPTH});
        if (rv && sz == 0) m_uf = 1'b1;
        if (rv && sz > 0) begin
            r      = mq.pop_front();
            e_upd  = 1'b1;
            e_addr = r.pc[6:2];
            e_mis  = (r.pred != rt);
            e_redir = rt ? tgt : r.pc + 64'd4;
        end
        if (e_mis) begin
            mq.delete();
        end else if (fv && sz < DEPTH) begin
            mq.push_back('{pc: pc, pred: pt});
        end
        @(posedge clk);
        #1;
        fetch_valid   = 1'b0;
        resolve_valid = 1'b0;
        chk("upd_valid", {63'd0, upd_valid}, {63'd0, e_upd});
        if (e_upd) begin
            chk("upd_addr", {59'd0, upd_addr}, {59'd0, e_addr});
            chk("upd_taken", {63'd0, upd_taken}, {63'd0, rt});
        end
        chk("mispredict", {63'd0, mispredict}, {63'd0, e_mis});
        if (e_mis) chk("redirect_pc", redirect_pc, e_redir);
        chk("occupancy", {61'd0, occupancy}, 64'(mq.size()));
        chk("underflow_err", {63'd0, underflow_err}, {63'd0, m_uf});
    endtask

    task automatic do_reset(input logic rv);
        rst           = 1'b1;
        resolve_valid = rv;
        resolve_taken = 1'b1;
        fetch_valid   = 1'b0;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        resolve_valid = 1'b0;
        mq.delete();
        m_uf = 1'b0;
        chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
        chk("rst_upd_addr", {59'd0, upd_addr}, 64'd0);
        chk("rst_upd_taken", {63'd0, upd_taken}, 64'd0);
        chk("rst_mispredict", {63'd0, mispredict}, 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_occupancy", {61'd0, occupancy}, 64'd0);
        chk("rst_fetch_ready", {63'd0, fetch_ready}, 64'd1);
        chk("rst_underflow", {63'd0, underflow_err}, 64'd0);
    endtask

    initial begin
        do_reset(1'b0);

        // 1: correct taken prediction
        cyc(1, 64'h40, 1, 0, 0, 0);
        chk("t1_occ1", {61'd0, occupancy}, 64'd1);
        cyc(0, 0, 0, 1, 1, 64'h80);
        chk("t1_addr", {59'd0, upd_addr}, 64'h10);
        chk("t1_occ0", {61'd0, occupancy}, 64'd0);

        // 2: predicted taken, actually not taken
        cyc(1, 64'h44, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 64'h999);
        chk("t2_redirect", redirect_pc, 64'h48);
        chk("t2_addr", {59'd0, upd_addr}, 64'h11);

        // 3: mispredict flushes younger records and drops the concurrent push
        cyc(1, 64'h100, 0, 0, 0, 0);
        cyc(1, 64'h104, 0, 0, 0, 0);
        cyc(1, 64'h108, 0, 0, 0, 0);
        cyc(1, 64'h10C, 0, 1, 1, 64'h200);
        chk("t3_redirect", redirect_pc, 64'h200);
        chk("t3_occ", {61'd0, occupancy}, 64'd0);

        // 4: fill, push while full is ignored, drain in order
        cyc(1, 64'h200, 1, 0, 0, 0);
        cyc(1, 64'h204, 0, 0, 0, 0);
        cyc(1, 64'h208, 1, 0, 0, 0);
        cyc(1, 64'h20C, 0, 0, 0, 0);
        chk("t4_full_ready", {63'd0, fetch_ready}, 64'd0);
        cyc(1, 64'h500, 1, 0, 0, 0);
        chk("t4_full_occ", {61'd0, occupancy}, 64'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, (i % 2 == 0), 64'h300);
            chk("t4_order", {59'd0, upd_addr}, 64'(5'h00 + 5'(i)));
        end

        // 5: resolve on empty queue sets sticky error
        cyc(0, 0, 0, 1, 1, 64'h300);
        chk("t5_uf", {63'd0, underflow_err}, 64'd1);
        cyc(1, 64'h600, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // 6: reset mid-operation with a resolve pending
        cyc(1, 64'h700, 0, 0, 0, 0);
        cyc(1, 64'h704, 0, 0, 0, 0);
        do_reset(1'b1);

        // redirect pc+4 wraps at the top of the address space
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("wrap_redirect", redirect_pc, 64'd0);

        // random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom),
                ($urandom_range(0, 2) == 0), 1'($urandom), {$urandom, $urandom});
            if (n == 200) do_reset(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
